// File: rtl/pdm_speaker_tx_pkg.sv
// Shared definitions for the PDM speaker playback path: FSM encoding and default parameters.
package pdm_speaker_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int PCM_W_DEF      = 16;
  localparam int CLK_DIV_DEF    = 50;
  localparam int DECIM_DEF      = 64;
  localparam int FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/pdm_speaker_tx_pcm_fifo.sv
// Small synchronous sample FIFO with show-ahead read; pops only from registered non-empty state.
module pcm_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  din,
  input  logic          wr,
  input  logic          rd,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign level = count;
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(wr_en) - LW'(rd_en);
    end
  end

endmodule

// File: rtl/pdm_speaker_tx.sv
// PCM-to-PDM playback: sample FIFO, bit-rate divider, first-order sigma-delta modulator and
// amplifier control FSM.
module pdm_speaker_tx
  import pdm_speaker_tx_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int PCM_W      = PCM_W_DEF,
  parameter int DECIM      = DECIM_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [PCM_W-1:0]              pcm_data,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          mclk,
  output logic                          ampPWM,
  output logic                          ampSD,
  output logic                          underrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(DECIM);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [SW-1:0] SMP_LAST = SW'(DECIM - 1);

  state_t           state;
  state_t           state_next;
  logic [DW-1:0]    div_cnt;
  logic [SW-1:0]    smp_cnt;
  logic [PCM_W-1:0] acc;
  logic [PCM_W-1:0] cur_sample;
  logic [PCM_W-1:0] u;
  logic [PCM_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             bit_tick;
  logic             smp_last;
  logic             pop;

  pcm_fifo #(
    .W     (PCM_W),
    .DEPTH (FIFO_DEPTH),
    .LW    ($clog2(FIFO_DEPTH) + 1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (pcm_data),
    .wr    (pcm_valid),
    .rd    (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign pcm_ready = !fifo_full;
  assign bit_tick  = (state != IDLE) && (div_cnt == DIV_LAST);
  assign smp_last  = (smp_cnt == SMP_LAST);
  // Offset binary: flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1.
  assign u         = {~cur_sample[PCM_W-1], cur_sample[PCM_W-2:0]};
  assign pop       = enable && bit_tick && !fifo_empty &&
                     ((state == START) || ((state == RUN) && smp_last));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = START;
        START:   if (bit_tick && !fifo_empty) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ampSD = (state == RUN);
    mclk  = (state != IDLE) && (div_cnt < DIV_HALF);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt    <= '0;
      smp_cnt    <= '0;
      acc        <= '0;
      cur_sample <= '0;
      ampPWM     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (!enable || state == IDLE) begin
        div_cnt <= '0;
        smp_cnt <= '0;
        acc     <= '0;
        ampPWM  <= 1'b0;
      end else begin
        div_cnt <= bit_tick ? '0 : div_cnt + 1'b1;
        if (state == START && bit_tick && !fifo_empty) begin
          cur_sample <= fifo_dout;
          smp_cnt    <= '0;
          acc        <= '0;
        end
        if (state == RUN && bit_tick) begin
          {ampPWM, acc} <= {1'b0, acc} + {1'b0, u};
          smp_cnt       <= smp_last ? '0 : smp_cnt + 1'b1;
          // On an empty FIFO the current sample simply repeats.
          if (smp_last) begin
            if (!fifo_empty) cur_sample <= fifo_dout;
            else             underrun   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_speaker_tx.sv
// Scoreboard bench for pdm_speaker_tx with CLK_DIV=4, DECIM=8, PCM_W=16, FIFO_DEPTH=8.
module tb_pdm_speaker_tx;

  localparam int DECIM = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pcm_data = '0;
  logic        pcm_valid = 1'b0;
  logic        pcm_ready;
  logic [3:0]  fifo_level;
  logic        mclk;
  logic        ampPWM;
  logic        ampSD;
  logic        underrun;

  typedef struct {
    logic b;
    logic u;
  } exp_t;

  exp_t        sb [$];
  int          check_count = 0;
  int          error_count = 0;
  int          consumed = 0;
  int          ones = 0;
  logic [15:0] m_acc = '0;
  logic        prev_mclk = 1'b0;
  logic        prev_sd = 1'b0;

  always #5 clk = ~clk;

  pdm_speaker_tx #(
    .CLK_DIV    (4),
    .PCM_W      (16),
    .DECIM      (DECIM),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pcm_data   (pcm_data),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .fifo_level (fifo_level),
    .mclk       (mclk),
    .ampPWM     (ampPWM),
    .ampSD      (ampSD),
    .underrun   (underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected PDM bits for one sample, from the first-order sigma-delta definition.
  task automatic push_sample(input logic [15:0] s, input logic urun_end);
    logic [16:0] sum;
    exp_t e;
    for (int i = 0; i < DECIM; i++) begin
      sum   = {1'b0, m_acc} + {1'b0, s ^ 16'h8000};
      m_acc = sum[15:0];
      e.b   = sum[16];
      e.u   = (i == DECIM - 1) && urun_end;
      sb.push_back(e);
    end
  endtask

  task automatic write_word(input logic [15:0] d);
    @(posedge clk); #1;
    pcm_data  = d;
    pcm_valid = 1'b1;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    $display("write data=%04h level=%0d ready=%0b", d, fifo_level, pcm_ready);
  endtask

  task automatic wait_consumed(input int target);
    int n = 0;
    while (consumed < target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("bit_count_timeout", consumed >= target, 1);
  endtask

  task automatic wait_sd();
    int n = 0;
    while (ampSD !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ampsd_on_run", ampSD, 1);
  endtask

  // A PDM bit is observed at each mclk rise that follows a bit period already in RUN.
  always @(negedge clk) begin
    exp_t e;
    if (reset && mclk && !prev_mclk && prev_sd && ampSD && sb.size() > 0) begin
      e = sb.pop_front();
      $display("bit %0d pwm=%0b exp=%0b underrun=%0b", consumed, ampPWM, e.b, underrun);
      check_eq("pdm_bit", ampPWM, e.b);
      check_eq("underrun_at_bit", underrun, e.u);
      consumed++;
      ones += int'(ampPWM);
    end
    prev_mclk = mclk;
    prev_sd   = ampSD;
  end

  initial begin
    int base;
    int ones_base;
    logic [15:0] words [9];
    words[0] = 16'h4000; words[1] = 16'h1234; words[2] = 16'hC000;
    words[3] = 16'h0001; words[4] = 16'hFFFF; words[5] = 16'h8000;
    words[6] = 16'h7FFF; words[7] = 16'h2000; words[8] = 16'hAAAA;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ampPWM", ampPWM, 0);
    check_eq("rst_ampSD", ampSD, 0);
    check_eq("rst_mclk", mclk, 0);
    check_eq("rst_ready", pcm_ready, 1);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_underrun", underrun, 0);
    reset = 1'b1;

    // 0x0000, 0x8000, 0x7FFF then the last sample repeats after underrun
    write_word(16'h0000);
    write_word(16'h8000);
    write_word(16'h7FFF);
    check_eq("level_three", fifo_level, 3);
    m_acc = '0;
    push_sample(16'h0000, 1'b0);
    push_sample(16'h8000, 1'b0);
    push_sample(16'h7FFF, 1'b1);
    push_sample(16'h7FFF, 1'b1);
    enable = 1'b1;
    wait_sd();
    check_eq("pwm_at_run_entry", ampPWM, 0);
    check_eq("level_after_first_pop", fifo_level, 2);
    wait_consumed(32);
    check_eq("sb_drained_a", sb.size(), 0);

    // Disable mid-run
    enable = 1'b0;
    @(posedge clk); #1;
    check_eq("dis_ampSD", ampSD, 0);
    check_eq("dis_mclk", mclk, 0);
    check_eq("dis_ampPWM", ampPWM, 0);
    check_eq("dis_level", fifo_level, 0);

    // Fill while stopped; ninth word refused
    for (int i = 0; i < 9; i++) begin
      write_word(words[i]);
      check_eq("fill_ready", pcm_ready, (i < 7) ? 1 : 0);
      check_eq("fill_level", fifo_level, (i < 8) ? i + 1 : 8);
      check_eq("fill_ampSD", ampSD, 0);
    end

    // Play three samples, then stop with the FIFO holding the rest
    m_acc = '0;
    base  = consumed;
    for (int i = 0; i < 3; i++) push_sample(words[i], 1'b0);
    enable = 1'b1;
    wait_sd();
    wait_consumed(base + 24);
    enable = 1'b0;
    @(posedge clk); #1;
    check_eq("stop_ampSD", ampSD, 0);
    check_eq("stop_level_kept", fifo_level, 4);
    repeat (5) @(posedge clk);
    #1;
    check_eq("stop_level_still", fifo_level, 4);
    sb.delete();

    // Reset in the middle of RUN
    enable = 1'b1;
    wait_sd();
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_ampSD", ampSD, 0);
    check_eq("mid_rst_ampPWM", ampPWM, 0);
    check_eq("mid_rst_mclk", mclk, 0);
    check_eq("mid_rst_level", fifo_level, 0);
    check_eq("mid_rst_ready", pcm_ready, 1);
    check_eq("mid_rst_underrun", underrun, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Single 0x4000 repeated under underrun: density 3/4
    write_word(16'h4000);
    m_acc = '0;
    base  = consumed;
    for (int i = 0; i < 3; i++) push_sample(16'h4000, 1'b1);
    ones_base = ones;
    enable = 1'b1;
    wait_sd();
    wait_consumed(base + 24);
    check_eq("density_4000", ones - ones_base, 18);
    enable = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
